activate_seq: RTL

- Sequential, parametrised successor to the combinational vector activation stage in the RNN datapath.
- Latches a full INPUT_SIZE-element fixed-point vector on a start pulse and applies a run-time selectable activation (tanh, sigmoid, relu, identity).
- Processes LANES elements per cycle through a 3-stage shift-add pipeline.
- Presents the packed result vector with a done pulse; sits between the gate accumulators and the hidden-state register.

---
 rtl/activate_pkg.sv | 43 ++++
 rtl/activate_seq_lane.sv | 123 ++++++++++++
 rtl/activate_seq.sv | 133 +++++++++++++
 3 files changed

// File: rtl/activate_pkg.sv
// Shared encodings and fixed-point constants for the activation sequencer.
package activate_pkg;

  localparam logic [1:0] ACT_TANH    = 2'b00;
  localparam logic [1:0] ACT_SIGMOID = 2'b01;
  localparam logic [1:0] ACT_RELU    = 2'b10;
  localparam logic [1:0] ACT_ID      = 2'b11;

  localparam int PIPE_DEPTH = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // PLAN sigmoid breakpoints/offsets in Q.frac; frac must be at least 5
  function automatic longint q_one(input int frac);
    return longint'(1) << frac;
  endfunction

  function automatic longint q_bp_hi(input int frac);
    return longint'(5) << frac;
  endfunction

  function automatic longint q_bp_mid(input int frac);
    return longint'(19) << (frac - 3);
  endfunction

  function automatic longint q_off_hi(input int frac);
    return longint'(27) << (frac - 5);
  endfunction

  function automatic longint q_off_mid(input int frac);
    return longint'(5) << (frac - 3);
  endfunction

  function automatic longint q_off_lo(input int frac);
    return longint'(1) << (frac - 1);
  endfunction

endpackage

// File: rtl/activate_seq_lane.sv
// Single-lane 3-stage activation pipeline: |x| prep, PLAN sigmoid, mode select + saturation.
module act_lane_pipe
  import activate_pkg::*;
#(
  parameter int BW_IN     = 32,
  parameter int BW_OUT    = 32,
  parameter int FRAC_BITS = 15,
  parameter int IDX_W     = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_in,
  input  logic [1:0]               mode_in,
  input  logic [IDX_W-1:0]         idx_in,
  input  logic signed [BW_IN-1:0]  x_in,
  output logic                     valid_out,
  output logic [IDX_W-1:0]         idx_out,
  output logic signed [BW_OUT-1:0] y_out
);

  localparam int W = BW_IN + 2;
  localparam int E = W + BW_OUT;

  localparam logic signed [W-1:0] ONE     = W'(q_one(FRAC_BITS));
  localparam logic signed [W-1:0] BP_HI   = W'(q_bp_hi(FRAC_BITS));
  localparam logic signed [W-1:0] BP_MID  = W'(q_bp_mid(FRAC_BITS));
  localparam logic signed [W-1:0] OFF_HI  = W'(q_off_hi(FRAC_BITS));
  localparam logic signed [W-1:0] OFF_MID = W'(q_off_mid(FRAC_BITS));
  localparam logic signed [W-1:0] OFF_LO  = W'(q_off_lo(FRAC_BITS));
  localparam logic signed [E-1:0] OUT_MAX = E'({1'b0, {(BW_OUT-1){1'b1}}});
  localparam logic signed [E-1:0] OUT_MIN = ~OUT_MAX;

  logic                    v1, v2;
  logic [1:0]              mode1, mode2;
  logic [IDX_W-1:0]        idx1, idx2;
  logic                    neg1, neg2;
  logic signed [BW_IN-1:0] x1, x2;
  logic signed [W-1:0]     z1, s2;

  logic signed [W-1:0]     x_ext, abs_c, z_c, s_c, t_c, r_c;
  logic signed [E-1:0]     r_ext, r_sat;
  logic signed [BW_OUT-1:0] y_c;

  // S1: magnitude with most-negative clamped to max positive
  always_comb begin
    x_ext = W'(x_in);
    if (x_in[BW_IN-1] && (x_in[BW_IN-2:0] == '0))
      abs_c = {3'b000, {(BW_IN-1){1'b1}}};
    else if (x_in[BW_IN-1])
      abs_c = -x_ext;
    else
      abs_c = x_ext;
    z_c = (mode_in == ACT_TANH) ? (abs_c <<< 1) : abs_c;
  end

  // S2: piecewise-linear sigmoid on z >= 0
  always_comb begin
    if (z1 >= BP_HI)
      s_c = ONE;
    else if (z1 >= BP_MID)
      s_c = (z1 >>> 5) + OFF_HI;
    else if (z1 >= ONE)
      s_c = (z1 >>> 3) + OFF_MID;
    else
      s_c = (z1 >>> 2) + OFF_LO;
  end

  // S3: fold sign back in per mode, then clamp to the output range
  always_comb begin
    t_c = (s2 <<< 1) - ONE;
    case (mode2)
      ACT_SIGMOID: r_c = neg2 ? (ONE - s2) : s2;
      ACT_TANH:    r_c = neg2 ? -t_c : t_c;
      ACT_RELU:    r_c = neg2 ? '0 : W'(x2);
      default:     r_c = W'(x2);
    endcase
    r_ext = E'(r_c);
    if (r_ext > OUT_MAX)
      r_sat = OUT_MAX;
    else if (r_ext < OUT_MIN)
      r_sat = OUT_MIN;
    else
      r_sat = r_ext;
    y_c = BW_OUT'(r_sat);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      valid_out <= 1'b0;
      mode1     <= ACT_TANH;
      mode2     <= ACT_TANH;
      idx1      <= '0;
      idx2      <= '0;
      idx_out   <= '0;
      neg1      <= 1'b0;
      neg2      <= 1'b0;
      x1        <= '0;
      x2        <= '0;
      z1        <= '0;
      s2        <= '0;
      y_out     <= '0;
    end else begin
      v1        <= valid_in;
      mode1     <= mode_in;
      idx1      <= idx_in;
      neg1      <= x_in[BW_IN-1];
      x1        <= x_in;
      z1        <= z_c;
      v2        <= v1;
      mode2     <= mode1;
      idx2      <= idx1;
      neg2      <= neg1;
      x2        <= x1;
      s2        <= s_c;
      valid_out <= v2;
      idx_out   <= idx2;
      y_out     <= y_c;
    end
  end

endmodule

// File: rtl/activate_seq.sv
// Sequential vector activation: latches a vector on start, streams LANES elements/cycle through
// act_lane_pipe instances and assembles the result vector.
//
// state    | meaning
// ST_IDLE  | waiting for start; result_bus holds last run
// ST_ISSUE | issuing LANES elements per cycle from the latched vector
// ST_DRAIN | PIPE_DEPTH cycles for the lanes to flush
// ST_DONE  | one-cycle done pulse
module activate_seq
  import activate_pkg::*;
#(
  parameter int INPUT_SIZE = 20,
  parameter int BW_IN      = 32,
  parameter int BW_OUT     = 32,
  parameter int FRAC_BITS  = 15,
  parameter int LANES      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [1:0]                   mode,
  input  logic [INPUT_SIZE*BW_IN-1:0]  vectorA_bus,
  output logic [INPUT_SIZE*BW_OUT-1:0] result_bus,
  output logic                         busy,
  output logic                         done
);

  localparam int IDX_W = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(INPUT_SIZE - LANES);
  localparam logic [IDX_W-1:0] STEP       = IDX_W'(LANES);
  localparam logic [1:0]       DRAIN_INIT = 2'(PIPE_DEPTH - 1);

  if ((INPUT_SIZE % LANES) != 0) begin : g_size_check
    $error("activate_seq: INPUT_SIZE must be a multiple of LANES");
  end

  state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       drain_q, drain_d;
  logic [1:0]       mode_q;
  logic             latch, issue;

  logic signed [BW_IN-1:0]  vec_q [INPUT_SIZE];
  logic signed [BW_OUT-1:0] res_q [INPUT_SIZE];

  logic [LANES-1:0]         lane_v;
  logic [IDX_W-1:0]         lane_idx [LANES];
  logic signed [BW_OUT-1:0] lane_y   [LANES];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    drain_d = drain_q;
    latch   = 1'b0;
    issue   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          latch   = 1'b1;
          idx_d   = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        issue = 1'b1;
        if (idx_q == LAST_IDX) begin
          drain_d = DRAIN_INIT;
          state_d = ST_DRAIN;
        end else begin
          idx_d = idx_q + STEP;
        end
      end
      ST_DRAIN: begin
        if (drain_q == 2'd0)
          state_d = ST_DONE;
        else
          drain_d = drain_q - 2'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign done = (state_q == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      drain_q <= 2'd0;
      mode_q  <= ACT_TANH;
      for (int e = 0; e < INPUT_SIZE; e++) begin
        vec_q[e] <= '0;
        res_q[e] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      drain_q <= drain_d;
      if (latch) begin
        mode_q <= mode;
        for (int e = 0; e < INPUT_SIZE; e++)
          vec_q[e] <= vectorA_bus[e*BW_IN +: BW_IN];
      end
      for (int l = 0; l < LANES; l++)
        if (lane_v[l]) res_q[lane_idx[l]] <= lane_y[l];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    act_lane_pipe #(
      .BW_IN    (BW_IN),
      .BW_OUT   (BW_OUT),
      .FRAC_BITS(FRAC_BITS),
      .IDX_W    (IDX_W)
    ) u_pipe (
      .clk      (clk),
      .rst      (rst),
      .valid_in (issue),
      .mode_in  (mode_q),
      .idx_in   (idx_q + IDX_W'(l)),
      .x_in     (vec_q[idx_q + IDX_W'(l)]),
      .valid_out(lane_v[l]),
      .idx_out  (lane_idx[l]),
      .y_out    (lane_y[l])
    );
  end

  for (genvar e = 0; e < INPUT_SIZE; e++) begin : g_pack
    assign result_bus[e*BW_OUT +: BW_OUT] = res_q[e];
  end

endmodule
